// File: rtl/le_init_addr_pipe_pkg.sv
// Shared turbo-decoder constants and FSM state encoding for the Le init-address snapshot pipe.
// The optional overflow check is enabled by defining LE_INIT_OVF_CHK_EN.
package le_init_addr_pipe_pkg;

   localparam int CMP_COUNTER_WIDTH = 13;
   localparam int WINDOW_WIDTH      = 5;
   localparam int DATA_ADDR_WIDTH   = 24;
   localparam int Q_UP_WIDTH        = 4;
   localparam int LEAD_W            = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } le_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/le_init_snap_chain.sv
// One channel's snapshot shift chain with a saturating capture counter.
// Output is the oldest stage; valid once DEPTH captures have been taken since the last clear.
module le_init_snap_chain
   import le_init_addr_pipe_pkg::*;
#(
   parameter int DW    = DATA_ADDR_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clr,
   input  logic          i_shift,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_data,
   output logic          o_vld
);

   localparam int            CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [DW-1:0] r_stage [DEPTH];
   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
         r_cnt <= '0;
      end else if (i_clr) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
         r_cnt <= '0;
      end else if (i_shift) begin
         r_stage[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
         if (r_cnt != FULL) r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_data = r_stage[DEPTH-1];
   assign o_vld  = (r_cnt == FULL);

endmodule

// File: rtl/le_init_addr_pipe.sv
// Window-boundary snapshot of NCH init-address words with start/done FSM and per-channel leads.
// Define LE_INIT_OVF_CHK_EN to build the sticky o_ovf_err address-overflow check.
module le_init_addr_pipe
   import le_init_addr_pipe_pkg::*;
#(
   parameter int                    NCH   = 2,
   parameter int                    DW    = max_int(DATA_ADDR_WIDTH, 24),
   parameter int                    CNT_W = CMP_COUNTER_WIDTH,
   parameter int                    WIN_W = WINDOW_WIDTH,
   parameter int                    Q_W   = Q_UP_WIDTH,
   parameter int                    DEPTH = 2,
   parameter logic [LEAD_W*NCH-1:0] LEADS = {8'd2, 8'd1}
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_cmp_en,
   input  logic [CNT_W-1:0]   i_cmp_cnt,
   input  logic [WIN_W-1:0]   i_r,
   input  logic [Q_W-1:0]     i_q_up,
   input  logic [CNT_W-1:0]   i_block_size,
   input  logic [NCH*DW-1:0]  i_req,
   output logic [NCH*DW-1:0]  o_init_out,
   output logic [NCH-1:0]     o_init_vld,
   output logic               o_busy,
   output logic               o_done
`ifdef LE_INIT_OVF_CHK_EN
   ,output logic              o_ovf_err
`endif
);

   localparam int CW1 = CNT_W + 1;

   le_state_e        r_state;
   logic             r_busy;
   logic             r_done;
   logic             w_last;
   logic [CW1-1:0]   w_win_end;
   logic [NCH-1:0]   w_shift;

   assign w_last    = i_cmp_en & (i_cmp_cnt == i_block_size - CNT_W'(1));
   // Boundary just past the final full window; suppressed so a short last window is not double-captured.
   assign w_win_end = CW1'(i_q_up) << WIN_W;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (i_start) begin
         r_state <= ST_RUN;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_last) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         localparam logic [CW1-1:0] LEAD = CW1'(LEADS[LEAD_W*gi +: LEAD_W]);

         logic [CW1-1:0] w_c;
         logic           w_win;
         logic           w_hit_tail;
         logic           w_hit_mid;
         logic           w_trig;

         // Widened by one bit so cmp_cnt+lead and block_size-lead never wrap.
         assign w_c        = {1'b0, i_cmp_cnt} + LEAD;
         assign w_win      = (w_c[WIN_W-1:0] == '0);
         assign w_hit_tail = ({1'b0, i_block_size} >= LEAD) &&
                             ({1'b0, i_cmp_cnt} == ({1'b0, i_block_size} - LEAD));
         assign w_hit_mid  = w_win && (w_c != w_win_end);
         assign w_trig     = r_busy & i_cmp_en &
                             ((i_r == '0) ? w_win : (w_hit_tail | w_hit_mid));
         assign w_shift[gi] = w_trig & ~i_start;

         le_init_snap_chain #(
            .DW    (DW),
            .DEPTH (DEPTH)
         ) u_chain (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clr   (i_start),
            .i_shift (w_shift[gi]),
            .i_data  (i_req[gi*DW +: DW]),
            .o_data  (o_init_out[gi*DW +: DW]),
            .o_vld   (o_init_vld[gi])
         );
      end
   endgenerate

`ifdef LE_INIT_OVF_CHK_EN
   logic           r_ovf;
   logic [NCH-1:0] w_ovf_hit;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ovf
         assign w_ovf_hit[gi] = w_shift[gi] & (i_req[gi*DW +: CNT_W] >= i_block_size);
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)         r_ovf <= 1'b0;
      else if (i_start)     r_ovf <= 1'b0;
      else if (|w_ovf_hit)  r_ovf <= 1'b1;
   end

   assign o_ovf_err = r_ovf;
`endif

endmodule
